// File: rtl/gpr_scoreboard_pkg.sv
// gpr_scoreboard_pkg
// Shared constants and types for the GPR write scoreboard.
//   SB_AW       : register address width (2**SB_AW registers, r0 hardwired zero)
//   SB_CW       : per-register pending counter width
//   SB_MAXPEND  : most writes that may be in flight to one register
//   SB_REG_ZERO : index of the hardwired-zero register
//   pend_cnt_t  : pending-write counter type
package gpr_scoreboard_pkg;

  localparam int SB_AW       = 5;
  localparam int SB_CW       = 2;
  localparam int SB_MAXPEND  = (1 << SB_CW) - 1;
  localparam int SB_REG_ZERO = 0;

  typedef logic [SB_CW-1:0] pend_cnt_t;

endpackage

// File: rtl/gpr_sb_cell.sv
// gpr_sb_cell
// Pending-write counter for one architectural register.
// Ports:
//   Clk, Rst     : clock (rising edge), async active-high reset
//   Clr          : synchronous clear (pipeline flush), overrides inc/dec
//   inc_i        : an issued write to this register was accepted
//   dec_i        : a writeback to this register happens this cycle
//   cnt_o        : current pending count
//   sat_o        : count is at the maximum number of writes in flight
//   underflow_o  : writeback arrived with nothing pending (and no same-cycle issue)
module gpr_sb_cell
  import gpr_scoreboard_pkg::*;
#(
  parameter int CW = SB_CW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Clr,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o,
  output logic          underflow_o
);

  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_CNT = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  // An issue and a writeback in the same cycle cancel out. A writeback with
  // nothing pending leaves the count at zero and flags the underflow; the top
  // level qualifies the flag with Clr when folding it into Err.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (dec_i && !inc_i && (cnt_q == '0)) begin
      underflow_o = 1'b1;
    end
    if (Clr) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      cnt_d = cnt_q + ONE;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard
// Tracks in-flight writes per GPR between issue and writeback and stalls
// decode while a source register still has an unretired producer.
// Ports:
//   Clk, Rst          : clock (rising edge), async active-high reset
//   Clr               : synchronous flush of all pending state and Err
//   Iss_valid         : decode-stage instruction present
//   Iss_we, Iss_A3    : instruction writes a GPR, and which one
//   Use1/A1, Use2/A2  : source operand enables and addresses
//   Wb_We, Wb_A3      : writeback enable/address (shared with register file)
//   Stall             : decode held, issue not accepted this cycle
//   Busy1, Busy2      : source has an outstanding producer not bypassed now
//   InFlight          : total pending writes over all registers
//   Err               : sticky flag, writeback with nothing pending
module gpr_scoreboard
  import gpr_scoreboard_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int CW = SB_CW
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             Iss_valid,
  input  logic             Iss_we,
  input  logic [AW-1:0]    Iss_A3,
  input  logic             Use1,
  input  logic             Use2,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  input  logic             Wb_We,
  input  logic [AW-1:0]    Wb_A3,
  output logic             Stall,
  output logic             Busy1,
  output logic             Busy2,
  output logic [AW+CW-1:0] InFlight,
  output logic             Err
);

  localparam int NREG = 1 << AW;
  localparam logic [AW-1:0]    R0     = AW'(SB_REG_ZERO);
  localparam logic [CW-1:0]    ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW+CW-1:0] IF_ONE = {{(AW+CW-1){1'b0}}, 1'b1};

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] sat_vec;
  logic [NREG-1:0] uf_vec;

  logic wb_active, same_reg, acc, sat;
  logic wb_hit_a1, wb_hit_a2, wb_hit_a3;
  logic busy1, busy2;
  logic inf_inc, inf_dec;

  logic [AW+CW-1:0] in_flight_q, in_flight_d;
  logic             err_q, err_d;

  // Register zero never holds pending state.
  assign cnt[0]     = '0;
  assign sat_vec[0] = 1'b0;
  assign uf_vec[0]  = 1'b0;

  // One counter per writable register. The issue and writeback address
  // decoders are folded into each cell's inc/dec enables.
  for (genvar r = 1; r < NREG; r++) begin : g_cell
    gpr_sb_cell #(.CW(CW)) u_cell (
      .Clk         (Clk),
      .Rst         (Rst),
      .Clr         (Clr),
      .inc_i       (acc && (Iss_A3 == AW'(r))),
      .dec_i       (wb_active && (Wb_A3 == AW'(r))),
      .cnt_o       (cnt[r]),
      .sat_o       (sat_vec[r]),
      .underflow_o (uf_vec[r])
    );
  end

  // Busy/stall decision. A source whose only pending write retires this
  // cycle is not busy because the register file writes through. A saturated
  // destination may still issue if one of its writes retires this cycle.
  always_comb begin
    wb_active = Wb_We && (Wb_A3 != R0);
    wb_hit_a1 = wb_active && (Wb_A3 == A1);
    wb_hit_a2 = wb_active && (Wb_A3 == A2);
    wb_hit_a3 = wb_active && (Wb_A3 == Iss_A3);
    busy1 = Use1 && (A1 != R0) && (cnt[A1] != '0) && !(wb_hit_a1 && (cnt[A1] == ONE));
    busy2 = Use2 && (A2 != R0) && (cnt[A2] != '0) && !(wb_hit_a2 && (cnt[A2] == ONE));
    sat   = Iss_we && (Iss_A3 != R0) && sat_vec[Iss_A3] && !wb_hit_a3;
    Stall = Iss_valid && (busy1 || busy2 || sat);
    acc   = Iss_valid && Iss_we && !Stall && (Iss_A3 != R0);
  end

  // InFlight tracks the counter sum: a same-register issue/writeback pair
  // leaves both unchanged, and an underflowing writeback removes nothing.
  always_comb begin
    same_reg    = acc && wb_hit_a3;
    inf_inc     = acc && !same_reg;
    inf_dec     = wb_active && (cnt[Wb_A3] != '0) && !same_reg;
    in_flight_d = in_flight_q;
    err_d       = err_q | (|uf_vec);
    if (Clr) begin
      in_flight_d = '0;
      err_d       = 1'b0;
    end else if (inf_inc && !inf_dec) begin
      in_flight_d = in_flight_q + IF_ONE;
    end else if (inf_dec && !inf_inc) begin
      in_flight_d = in_flight_q - IF_ONE;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

  assign Busy1    = busy1;
  assign Busy2    = busy2;
  assign InFlight = in_flight_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// tb_gpr_scoreboard
// Directed bench for gpr_scoreboard: reset/idle, RAW stall with writeback
// bypass, same-cycle issue+writeback, saturation, register zero, underflow
// Err, synchronous clear and asynchronous reset.
module tb_gpr_scoreboard;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Clr = 1'b0;
  logic       Iss_valid = 1'b0;
  logic       Iss_we = 1'b0;
  logic [4:0] Iss_A3 = '0;
  logic       Use1 = 1'b0;
  logic       Use2 = 1'b0;
  logic [4:0] A1 = '0;
  logic [4:0] A2 = '0;
  logic       Wb_We = 1'b0;
  logic [4:0] Wb_A3 = '0;
  logic       Stall, Busy1, Busy2, Err;
  logic [6:0] InFlight;

  int errors = 0;
  int checks = 0;

  gpr_scoreboard dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Clr       (Clr),
    .Iss_valid (Iss_valid),
    .Iss_we    (Iss_we),
    .Iss_A3    (Iss_A3),
    .Use1      (Use1),
    .Use2      (Use2),
    .A1        (A1),
    .A2        (A2),
    .Wb_We     (Wb_We),
    .Wb_A3     (Wb_A3),
    .Stall     (Stall),
    .Busy1     (Busy1),
    .Busy2     (Busy2),
    .InFlight  (InFlight),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle's worth of inputs; everything not named goes idle.
  task automatic applyStimulus(input logic v, input logic we, input logic [4:0] a3,
                               input logic u1, input logic [4:0] a1,
                               input logic u2, input logic [4:0] a2,
                               input logic wbe, input logic [4:0] wba3);
    Iss_valid = v;  Iss_we = we;  Iss_A3 = a3;
    Use1 = u1;  A1 = a1;  Use2 = u2;  A2 = a2;
    Wb_We = wbe;  Wb_A3 = wba3;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic eStall, input logic eB1,
                             input logic eB2, input logic [6:0] eIf, input logic eErr);
    checks++;
    assert (Stall === eStall) else begin
      errors++;
      $error("[TB] FAIL %s Stall: observed %b expected %b", tag, Stall, eStall);
    end
    checks++;
    assert (Busy1 === eB1) else begin
      errors++;
      $error("[TB] FAIL %s Busy1: observed %b expected %b", tag, Busy1, eB1);
    end
    checks++;
    assert (Busy2 === eB2) else begin
      errors++;
      $error("[TB] FAIL %s Busy2: observed %b expected %b", tag, Busy2, eB2);
    end
    checks++;
    assert (InFlight === eIf) else begin
      errors++;
      $error("[TB] FAIL %s InFlight: observed %0d expected %0d", tag, InFlight, eIf);
    end
    checks++;
    assert (Err === eErr) else begin
      errors++;
      $error("[TB] FAIL %s Err: observed %b expected %b", tag, Err, eErr);
    end
  endtask

  initial begin
    // Reset and idle
    #12 Rst = 1'b0;
    applyStimulus(1, 0, 0, 1, 5, 0, 0, 0, 0);
    checkOutput("reset_idle", 0, 0, 0, 0, 0);
    tick();

    // RAW stall on r8, released by the writeback bypass
    applyStimulus(1, 1, 8, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_issue", 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 8, 0, 0, 0, 0);
    checkOutput("raw_c1", 1, 1, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 8, 0, 0, 0, 0);
    checkOutput("raw_c2", 1, 1, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 8, 0, 0, 1, 8);
    checkOutput("raw_bypass", 0, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 8, 0, 0, 0, 0);
    checkOutput("raw_retired", 0, 0, 0, 0, 0);
    tick();

    // Same-cycle issue and writeback on r3 with one pending
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 1, 3);
    checkOutput("r3_pair", 0, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0);
    checkOutput("r3_still_busy", 1, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3);
    tick();
    idle();
    checkOutput("r3_drained", 0, 0, 0, 0, 0);

    // Saturation of r9
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 9, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(1, 1, 9, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_stall", 1, 0, 0, 3, 0);
    tick();
    idle();
    checkOutput("sat_hold", 0, 0, 0, 3, 0);
    applyStimulus(1, 1, 9, 0, 0, 0, 0, 1, 9);
    checkOutput("sat_wb_accept", 0, 0, 0, 3, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 9, 0, 0, 1, 9);
    checkOutput("sat_multi_busy", 1, 1, 0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
      tick();
    end
    idle();
    checkOutput("sat_drained", 0, 0, 0, 0, 0);

    // Register zero is never tracked
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("r0_cycle", 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    checkOutput("r0_after", 0, 0, 0, 0, 0);

    // Underflow sets sticky Err
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12);
    checkOutput("uf_before", 0, 0, 0, 0, 0);
    tick();
    idle();
    checkOutput("uf_set", 0, 0, 0, 0, 1);
    tick();
    checkOutput("uf_sticky", 0, 0, 0, 0, 1);

    // Clr with two pending on r4 overrides a same-cycle issue/writeback
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    checkOutput("clr_before", 0, 0, 0, 2, 1);
    Clr = 1'b1;
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 1, 4);
    tick();
    Clr = 1'b0;
    applyStimulus(1, 0, 0, 1, 4, 1, 5, 0, 0);
    checkOutput("clr_after", 0, 0, 0, 0, 0);
    tick();

    // Asynchronous reset between clock edges
    applyStimulus(1, 1, 6, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12);
    tick();
    applyStimulus(1, 0, 0, 1, 6, 0, 0, 0, 0);
    checkOutput("arst_before", 1, 1, 0, 1, 1);
    #3 Rst = 1'b1;
    #1;
    checkOutput("arst_mid", 0, 0, 0, 0, 0);
    #1 Rst = 1'b0;
    tick();
    checkOutput("arst_after", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpr_scoreboard.md
Name: gpr_scoreboard

Overview:
Write-side tracker for the 32x32 general-purpose register file. It counts in-flight writes per architectural register between decode (issue) and writeback, and raises Stall when a decode-stage source register still has an unretired producer. Writeback shares the We/A3 signals driven into the register file. The writeback-cycle bypass matches the register file's same-cycle write-through.

Parameters:
AW, 5, register address width (2**AW registers; register 0 hardwired zero)
CW, 2, per-register pending counter width; MAXPEND = 2**CW-1 = 3 writes in flight per register

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-high
Clr  in  1  synchronous clear of all pending state (pipeline flush)
Iss_valid  in  1  decode-stage instruction present
Iss_we  in  1  instruction writes a GPR
Iss_A3  in  AW  destination register of the issuing instruction
Use1  in  1  instruction reads source A1
Use2  in  1  instruction reads source A2
A1  in  AW  source register 1 (same address as register-file A1)
A2  in  AW  source register 2
Wb_We  in  1  writeback write enable (same signal as register-file We)
Wb_A3  in  AW  writeback destination (same signal as register-file A3)
Stall  out  1  hold decode stage; issue not accepted this cycle
Busy1  out  1  A1 has an outstanding producer not satisfied this cycle
Busy2  out  1  A2 has an outstanding producer not satisfied this cycle
InFlight  out  AW+CW  total pending writes across all registers
Err  out  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (Rst=1, async): all counters 0, InFlight=0, Err=0. Therefore Busy1=Busy2=0 and Stall=0.
- Clr (sync, clock edge): all counters and InFlight go to 0 and Err to 0. Clr overrides issue and writeback in the same cycle.
- cnt[r] is a CW-bit counter per register. cnt[0] is always 0: issue and writeback to r0 are ignored and never cause Err.
- wb_hit(r) = Wb_We && Wb_A3==r && r!=0.
- Busy1 = Use1 && A1!=0 && cnt[A1]!=0 && !(wb_hit(A1) && cnt[A1]==1).
  - Rationale: the last pending write retiring this cycle is forwarded by the register file.
- Busy2: same form, using Use2 and A2.
- sat = Iss_we && Iss_A3!=0 && cnt[Iss_A3]==MAXPEND && !wb_hit(Iss_A3).
- Stall = Iss_valid && (Busy1 || Busy2 || sat). All outputs are combinational from state and the current inputs; no output registers.
- Issue accepted: acc = Iss_valid && Iss_we && !Stall && Iss_A3!=0.
- Per-register update on each clock edge:
  - acc only: +1.
  - wb_hit only: -1 if cnt>0. If cnt==0, the counter stays 0 and Err is set.
  - acc and wb_hit on the same register: unchanged.
  - acc and wb_hit on different registers: each is updated independently.
- InFlight = sum of counters, kept as a register updated by +acc - (valid decrement). It must equal the sum of all cnt[r] at every cycle boundary.
- Latency:
  - Issue in cycle N makes the register busy for a dependent source from cycle N+1.
  - Writeback in cycle M clears a single-pending register for sources in cycle M itself (bypass), and in state from M+1.
- Rst asserted mid-operation: immediate clear regardless of Clk. Deassertion is synchronous to the next edge by design of the upstream reset synchroniser.
- Err clears only on Rst or Clr.

Decomposition:
- Shared package: AW, CW, MAXPEND, register-zero constant (0), and a pending-counter typedef of CW bits.
- One natural sub-module: gpr_sb_cell. It holds one register's counter, performing inc/dec/hold with the zero-underflow flag and the MAXPEND saturation compare. It is instantiated 31 times (r1..r31) by generate; the top level contains the address decoders, the busy/stall logic, the InFlight accumulator and the Err flag.

Test Plan:
- Reset and idle: Rst pulse, then Iss_valid=1, Use1=1, A1=5 -> Busy1=0, Stall=0, InFlight=0.
- RAW stall and bypass release:
  - Issue we to r8 in cycle 0; cycle 1 issue Use1=1, A1=8 -> Stall=1.
  - Wb_We=1, Wb_A3=8 in cycle 3 -> Stall=0 in cycle 3; InFlight 1->0 after that edge.
- Same-cycle issue and writeback on r3 with cnt[3]=1: Iss_A3=3 accepted, Wb_A3=3 -> cnt[3] stays 1, InFlight unchanged; a following Use2, A2=3 -> Busy2=1.
- Saturation: three accepted writes to r9, then a fourth Iss_we to r9 with no writeback -> Stall=1 and cnt[9]=3. Same attempt with Wb_A3=9 -> accepted, cnt[9] stays 3.
- Register zero: Iss_A3=0 repeatedly, Use1 with A1=0, Wb_A3=0 with Wb_We=1 -> Busy1=0, InFlight=0, Err=0.
- Underflow, clear, and async reset:
  - Wb_We=1, Wb_A3=12 with cnt[12]=0 -> Err=1 sticky.
  - Clr with cnt[4]=2 -> next cycle all counters 0, Err=0.
  - Rst pulse between clock edges -> outputs clear before the next edge.
